// File: rtl/ball_render_ctrl.sv
// ball_render_ctrl: frame-tick driven erase/draw sequencer for the ball
// pixel-draw engine. Each pass optionally erases the ball at its previous
// position in BG_COLOUR, then draws it at the new position. Every engine
// pixel becomes one registered VGA plot strobe.
// Optional build macro FRAME_SKIP_CNT_EN adds skipCount, a saturating count
// of frame ticks that arrived while a pass was already in progress.
module ball_render_ctrl #(
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         TIMEOUT   = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       frameTick,
   input  logic [7:0] xBallNew,
   input  logic [6:0] yBallNew,
   input  logic [2:0] colourBall,
   output logic       drawEnable,
   output logic [7:0] xDrawCoord,
   output logic [6:0] yDrawCoord,
   input  logic [7:0] xPixIn,
   input  logic [6:0] yPixIn,
   input  logic       doneDraw,
   output logic [7:0] vgaX,
   output logic [6:0] vgaY,
   output logic [2:0] vgaColour,
   output logic       vgaPlot,
   output logic       busy,
   output logic       frameDone,
   output logic       timeoutErr
`ifdef FRAME_SKIP_CNT_EN
   ,
   output logic [7:0] skipCount
`endif
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_GAP_E,
      S_DRAW,
      S_GAP_D,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_x_new;
   logic [6:0]    r_y_new;
   logic [2:0]    r_colour;
   logic [7:0]    r_x_old;
   logic [6:0]    r_y_old;
   logic          r_has_old;
   logic          r_en_q;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_vga_x;
   logic [6:0]    r_vga_y;
   logic [2:0]    r_vga_c;
   logic          r_plot;
   logic          r_tmo_err;

   logic          w_in_phase;
   logic          w_done_seen;
   logic          w_tmo_hit;
   logic          w_phase_end;
   logic          w_abort;
   logic [2:0]    w_phase_colour;
   logic [7:0]    w_x_coord;
   logic [6:0]    w_y_coord;

   // Phase bookkeeping: a phase ends on a sampled done, or is aborted when the
   // cycle budget runs out first (done takes priority when both coincide).
   assign w_in_phase  = (r_state == S_ERASE) || (r_state == S_DRAW);
   assign w_done_seen = r_en_q && doneDraw;
   assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
   assign w_phase_end = w_in_phase && (w_done_seen || w_tmo_hit);
   assign w_abort     = w_in_phase && !w_done_seen && w_tmo_hit;

   // State register.
   always_ff @(posedge clock) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state and phase-dependent engine/plot controls.
   always_comb begin
      w_state_next   = r_state;
      w_phase_colour = BG_COLOUR;
      w_x_coord      = 8'd0;
      w_y_coord      = 7'd0;
      case (r_state)
         S_IDLE:  if (frameTick) w_state_next = r_has_old ? S_ERASE : S_DRAW;
         S_ERASE: begin
            w_x_coord      = r_x_old;
            w_y_coord      = r_y_old;
            w_phase_colour = BG_COLOUR;
            if (w_phase_end) w_state_next = S_GAP_E;
         end
         S_GAP_E: w_state_next = S_DRAW;
         S_DRAW: begin
            w_x_coord      = r_x_new;
            w_y_coord      = r_y_new;
            w_phase_colour = r_colour;
            if (w_phase_end) w_state_next = S_GAP_D;
         end
         S_GAP_D: w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Latch the new position/colour only when a tick is accepted from IDLE.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_x_new  <= 8'd0;
         r_y_new  <= 7'd0;
         r_colour <= 3'd0;
      end else if (r_state == S_IDLE && frameTick) begin
         r_x_new  <= xBallNew;
         r_y_new  <= yBallNew;
         r_colour <= colourBall;
      end
   end

   // Completed pass: the drawn position becomes the one to erase next time.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_x_old   <= 8'd0;
         r_y_old   <= 7'd0;
         r_has_old <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_x_old   <= r_x_new;
         r_y_old   <= r_y_new;
         r_has_old <= 1'b1;
      end
   end

   // Enable-delay flag and per-phase cycle counter; both are zero outside a
   // phase so each GAP cycle restarts the engine and the budget.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_en_q <= 1'b0;
         r_tmo  <= '0;
      end else begin
         r_en_q <= w_in_phase && !w_phase_end;
         r_tmo  <= w_in_phase ? r_tmo + TW'(1) : '0;
      end
   end

   // One registered plot per engine pixel while the enable-delay flag is up.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_vga_x <= 8'd0;
         r_vga_y <= 7'd0;
         r_vga_c <= 3'd0;
         r_plot  <= 1'b0;
      end else if (r_en_q && !doneDraw) begin
         r_vga_x <= xPixIn;
         r_vga_y <= yPixIn;
         r_vga_c <= w_phase_colour;
         r_plot  <= 1'b1;
      end else begin
         r_plot  <= 1'b0;
      end
   end

   // Sticky abort flag.
   always_ff @(posedge clock) begin
      if (!resetn)      r_tmo_err <= 1'b0;
      else if (w_abort) r_tmo_err <= 1'b1;
   end

`ifdef FRAME_SKIP_CNT_EN
   logic [7:0] r_skip;

   // Saturating count of ticks that arrive while a pass is running.
   always_ff @(posedge clock) begin
      if (!resetn)
         r_skip <= 8'd0;
      else if (r_state != S_IDLE && frameTick && r_skip != 8'hFF)
         r_skip <= r_skip + 8'd1;
   end

   assign skipCount = r_skip;
`endif

   assign drawEnable = w_in_phase;
   assign xDrawCoord = w_x_coord;
   assign yDrawCoord = w_y_coord;
   assign vgaX       = r_vga_x;
   assign vgaY       = r_vga_y;
   assign vgaColour  = r_vga_c;
   assign vgaPlot    = r_plot;
   assign busy       = (r_state != S_IDLE);
   assign frameDone  = (r_state == S_DONE);
   assign timeoutErr = r_tmo_err;

endmodule

// File: tb/tb_ball_render_ctrl.sv
// Bench for ball_render_ctrl: a 2x2 draw-engine model, table-driven render
// passes checked against an expected plot queue, and hand-written sequences
// for the timeout abort and the mid-pass reset.
module tb_ball_render_ctrl;

   logic       clock;
   logic       resetn;
   logic       frameTick;
   logic [7:0] xBallNew;
   logic [6:0] yBallNew;
   logic [2:0] colourBall;
   logic       drawEnable;
   logic [7:0] xDrawCoord;
   logic [6:0] yDrawCoord;
   logic [7:0] xPixIn;
   logic [6:0] yPixIn;
   logic       doneDraw;
   logic [7:0] vgaX;
   logic [6:0] vgaY;
   logic [2:0] vgaColour;
   logic       vgaPlot;
   logic       busy;
   logic       frameDone;
   logic       timeoutErr;
`ifdef FRAME_SKIP_CNT_EN
   logic [7:0] skipCount;
`endif

   ball_render_ctrl #(.BG_COLOUR(3'b000), .TIMEOUT(16)) dut (
      .clock(clock), .resetn(resetn), .frameTick(frameTick),
      .xBallNew(xBallNew), .yBallNew(yBallNew), .colourBall(colourBall),
      .drawEnable(drawEnable), .xDrawCoord(xDrawCoord), .yDrawCoord(yDrawCoord),
      .xPixIn(xPixIn), .yPixIn(yPixIn), .doneDraw(doneDraw),
      .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .vgaPlot(vgaPlot),
      .busy(busy), .frameDone(frameDone), .timeoutErr(timeoutErr)
`ifdef FRAME_SKIP_CNT_EN
      , .skipCount(skipCount)
`endif
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- 2x2 engine model ----------------
   // Emits (x,y),(x+1,y),(x,y+1),(x+1,y+1) on successive enabled edges, then
   // raises done; eng_hang suppresses done to force a timeout.
   logic [2:0] eng_cnt;
   bit         eng_hang;
   initial begin
      eng_cnt  = 3'd0;
      doneDraw = 1'b0;
      xPixIn   = 8'd0;
      yPixIn   = 7'd0;
      eng_hang = 1'b0;
   end
   always @(posedge clock) begin
      if (!drawEnable) begin
         eng_cnt  <= 3'd0;
         doneDraw <= 1'b0;
      end else if (eng_cnt < 3'd4) begin
         xPixIn   <= xDrawCoord + {7'd0, eng_cnt[0]};
         yPixIn   <= yDrawCoord + {6'd0, eng_cnt[1]};
         eng_cnt  <= eng_cnt + 3'd1;
         doneDraw <= 1'b0;
      end else begin
         doneDraw <= !eng_hang;
      end
   end

   // ---------------- scoreboard ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;
   int skip_total = 0;
   logic [17:0] exp_q[$];
   logic [17:0] got_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_exp(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      logic [7:0] x1;
      logic [6:0] y1;
      x1 = x + 8'd1;
      y1 = y + 7'd1;
      exp_q.push_back({x,  y,  c});
      exp_q.push_back({x1, y,  c});
      exp_q.push_back({x,  y1, c});
      exp_q.push_back({x1, y1, c});
   endtask

   task automatic compare_plots(input string name);
      int n;
      check({name, "_plot_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({name, "_plot"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   // Issues one accepted tick and watches the pass to completion, optionally
   // spamming ticks (with scrambled inputs) while busy.
   task automatic do_pass(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                          input bit spam, output int en_cyc, output int gap_cyc,
                          output int fd, output int ign);
      en_cyc = 0; gap_cyc = 0; fd = 0; ign = 0;
      @(negedge clock);
      frameTick = 1'b1; xBallNew = x; yBallNew = y; colourBall = c;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clock);
         if (vgaPlot) got_q.push_back({vgaX, vgaY, vgaColour});
         if (drawEnable) en_cyc++;
         if (busy && !drawEnable) gap_cyc++;
         if (frameDone) fd++;
         if (!busy) begin
            frameTick = 1'b0;
            break;
         end
         if (spam) begin
            frameTick  = 1'b1;
            xBallNew   = 8'($urandom_range(0, 255));
            yBallNew   = 7'($urandom_range(0, 127));
            colourBall = 3'($urandom_range(0, 7));
            ign++;
         end else begin
            frameTick = 1'b0;
         end
      end
      frameTick = 1'b0;
      check("busy_low_after_pass", busy, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      bit         erase;
      logic [7:0] ox;
      logic [6:0] oy;
      bit         spam;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int en_cyc, gap_cyc, fd, ign;

      vecs[0] = '{x:8'd10,  y:7'd20,  c:3'd4, erase:1'b0, ox:8'd0,   oy:7'd0,   spam:1'b0};
      vecs[1] = '{x:8'd12,  y:7'd20,  c:3'd4, erase:1'b1, ox:8'd10,  oy:7'd20,  spam:1'b0};
      vecs[2] = '{x:8'd40,  y:7'd50,  c:3'd2, erase:1'b1, ox:8'd12,  oy:7'd20,  spam:1'b1};
      vecs[3] = '{x:8'd255, y:7'd127, c:3'd7, erase:1'b1, ox:8'd40,  oy:7'd50,  spam:1'b0};

      resetn = 1'b0; frameTick = 1'b0;
      xBallNew = 8'd0; yBallNew = 7'd0; colourBall = 3'd0;
      repeat (3) @(negedge clock);
      check("rst_drawEnable", drawEnable, 0);
      check("rst_vgaPlot",    vgaPlot,    0);
      check("rst_vgaXYC",     {vgaX, vgaY, vgaColour}, 0);
      check("rst_coords",     {xDrawCoord, yDrawCoord}, 0);
      check("rst_busy",       busy,       0);
      check("rst_frameDone",  frameDone,  0);
      check("rst_timeoutErr", timeoutErr, 0);
`ifdef FRAME_SKIP_CNT_EN
      check("rst_skipCount",  skipCount,  0);
`endif
      resetn = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 4; i++) begin
         if (vecs[i].erase) push_exp(vecs[i].ox, vecs[i].oy, 3'b000);
         push_exp(vecs[i].x, vecs[i].y, vecs[i].c);
         do_pass(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].spam, en_cyc, gap_cyc, fd, ign);
         compare_plots($sformatf("vec%0d", i));
         check($sformatf("vec%0d_en_cycles", i), en_cyc, vecs[i].erase ? 12 : 6);
         check($sformatf("vec%0d_gap_cycles", i), gap_cyc, vecs[i].erase ? 3 : 2);
         check($sformatf("vec%0d_frameDone", i), fd, 1);
         if (vecs[i].spam) check("spam_ignored_nonzero", (ign > 0), 1);
         skip_total += ign;
`ifdef FRAME_SKIP_CNT_EN
         check($sformatf("vec%0d_skipCount", i), skipCount, skip_total);
`endif
      end
      check("no_timeout_yet", timeoutErr, 0);

      // Engine never finishes: each phase is cut at 16 enabled cycles.
      eng_hang = 1'b1;
      do_pass(8'd60, 7'd30, 3'd1, 1'b0, en_cyc, gap_cyc, fd, ign);
      eng_hang = 1'b0;
      got_q.delete();
      check("hang_en_cycles", en_cyc, 32);
      check("hang_gap_cycles", gap_cyc, 3);
      check("hang_frameDone", fd, 1);
      check("hang_timeoutErr", timeoutErr, 1);

      // Old position still advanced; error stays sticky.
      push_exp(8'd60, 7'd30, 3'b000);
      push_exp(8'd70, 7'd40, 3'd3);
      do_pass(8'd70, 7'd40, 3'd3, 1'b0, en_cyc, gap_cyc, fd, ign);
      compare_plots("after_hang");
      check("after_hang_frameDone", fd, 1);
      check("timeoutErr_sticky", timeoutErr, 1);

      // Reset in the middle of the draw phase.
      @(negedge clock);
      frameTick = 1'b1; xBallNew = 8'd80; yBallNew = 7'd90; colourBall = 3'd5;
      @(negedge clock);
      frameTick = 1'b0;
      begin
         bit hit;
         hit = 1'b0;
         for (int cyc = 0; cyc < 60; cyc++) begin
            if (vgaPlot && vgaColour == 3'd5) begin
               hit = 1'b1;
               break;
            end
            @(negedge clock);
         end
         check("mid_draw_reached", hit, 1);
      end
      resetn = 1'b0;
      @(negedge clock);
      check("midrst_vgaPlot",    vgaPlot,    0);
      check("midrst_drawEnable", drawEnable, 0);
      check("midrst_busy",       busy,       0);
      check("midrst_timeoutErr", timeoutErr, 0);
`ifdef FRAME_SKIP_CNT_EN
      check("midrst_skipCount",  skipCount,  0);
`endif
      resetn = 1'b1;
      got_q.delete();
      push_exp(8'd20, 7'd10, 3'd6);
      do_pass(8'd20, 7'd10, 3'd6, 1'b0, en_cyc, gap_cyc, fd, ign);
      compare_plots("post_reset");
      check("post_reset_en_cycles", en_cyc, 6);
      check("post_reset_frameDone", fd, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
